wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback result, which is the final selected result from the writeback stage;
  - results returned by the multi-cycle multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO.
- Grants the port once per cycle and stalls the writeback stage when it loses arbitration.
- Drives the registered register-file write interface.

Parameters:
P_WIDTH, 32, data width of results and register-file write data
P_DEPTH, 2, MDU result FIFO depth (power of 2, >=2)
P_MAX_WAIT, 4, maximum cycles the FIFO head may wait before forced service (>=1)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; one clock; reset is asynchronous and active-high
i_pipe_valid  input  1  writeback stage holds an instruction needing the write port
i_pipe_rd  input  5  destination register of the writeback instruction
i_pipe_data  input  P_WIDTH  writeback result
o_pipe_stall  output  1  writeback stage must hold; combinational from state and i_pipe_valid
i_mdu_valid  input  1  MDU result available
o_mdu_ready  output  1  FIFO can accept an entry; equals !full from registered count
i_mdu_rd  input  5  MDU destination register
i_mdu_data  input  P_WIDTH  MDU result
o_rf_we  output  1  register-file write enable (registered)
o_rf_rd  output  5  register-file write address (registered)
o_rf_wdata  output  P_WIDTH  register-file write data (registered)
o_busy  output  1  FIFO non-empty (registered count != 0)

Behaviour:
- Reset (async, while i_rst=1):
  - o_rf_we/o_rf_rd/o_rf_wdata = 0.
  - FIFO count = 0, wait counter = 0, state = S_NORMAL.
  - o_mdu_ready forced 0; o_pipe_stall = 0.
  - Any in-flight FIFO contents are discarded.
- Enqueue: occurs when i_mdu_valid && o_mdu_ready.
  - There is no bypass: an MDU result always enters the FIFO and is granted at earliest the next cycle.
- Each cycle exactly one of {pipe, mdu head, none} is granted.
- S_NORMAL:
  - If i_pipe_valid, grant pipe.
  - Else if count!=0, grant MDU head and dequeue.
  - o_pipe_stall = 0.
- S_FORCE:
  - If count!=0, grant MDU head and dequeue.
  - o_pipe_stall = i_pipe_valid.
  - Unconditionally return to S_NORMAL next cycle; exactly one forced drain per entry.
- S_NORMAL -> S_FORCE at end of cycle when, after this cycle's update, either:
  - count==P_DEPTH, or
  - wait counter >= P_MAX_WAIT.
- Wait counter:
  - Increments (saturating) each cycle count!=0 and the head is not dequeued.
  - Clears on any dequeue or when the FIFO is empty.
- Alternation: a FIFO still full after a forced drain re-enters S_FORCE after one S_NORMAL cycle. This yields 1:1 pipe/MDU alternation and no starvation of either requester.
- Latency: a grant in cycle N appears on o_rf_* in cycle N+1.
  - o_rf_we = granted && rd!=0.
  - A rd==0 request is still consumed (pipe not stalled, FIFO dequeued) but never writes.
  - With no grant, o_rf_we=0 and o_rf_rd/o_rf_wdata hold their previous values.
- Simultaneous enqueue and dequeue: count unchanged; pointers both advance; wrap at P_DEPTH.
- FIFO ordering: strict FIFO. Two MDU results to the same rd write in arrival order.

Optional Feature:
- WB_ARB_PERF_EN defined:
  - Adds output o_stall_cnt [31:0]: counts cycles with o_pipe_stall=1, wraps at 2^32.
  - Adds output o_force_cnt [31:0]: counts S_FORCE entries, wraps at 2^32.
  - Both reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic {S_NORMAL, S_FORCE} wb_arb_state_e;
  - struct wb_req_t {rd[4:0], data[P_WIDTH-1:0]} (default width);
  - constant for register-address width (5).
- Sub-module wb_fifo: parameterised synchronous FIFO (depth, entry type) with count, full, empty, push and pop. The arbiter FSM, wait counter and output registers stay in wb_port_arbiter.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, assert i_rst -> o_rf_we=0, o_busy=0, o_mdu_ready=0 during reset; after release o_mdu_ready=1 and no stale write ever appears.
- Pipe only: i_pipe_valid=1, rd=5, data=0xDEADBEEF -> next cycle o_rf_we=1, o_rf_rd=5, o_rf_wdata=0xDEADBEEF; o_pipe_stall never 1.
- Idle drain: MDU pushes rd=7, data=0x12 with pipe idle -> write on o_rf_* exactly 2 cycles after the push cycle; o_busy=1 for one cycle.
- Full FIFO with continuous pipe traffic: MDU pushes 2 entries with pipe valid every cycle -> S_FORCE entered, o_pipe_stall=1 for exactly one cycle per forced drain, MDU writes in push order, no pipe write lost.
- Starvation guard, P_DEPTH=4: pipe valid every cycle, one MDU entry -> forced write after P_MAX_WAIT=4 waiting cycles.
- rd==0 on both sources -> o_rf_we stays 0, pipe not stalled, FIFO count decrements.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } wb_arb_state_e;

  // Default-width write request (destination register plus result).
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback / MDU / register-file signal bundle for wb_port_arbiter.
// slave = the arbiter, master = the surrounding pipeline.
interface wb_port_arbiter_if #(
  parameter int P_WIDTH = 32
);
  import wb_arb_pkg::*;

  logic                 i_pipe_valid;
  logic [RF_ADDR_W-1:0] i_pipe_rd;
  logic [P_WIDTH-1:0]   i_pipe_data;
  logic                 o_pipe_stall;

  logic                 i_mdu_valid;
  logic                 o_mdu_ready;
  logic [RF_ADDR_W-1:0] i_mdu_rd;
  logic [P_WIDTH-1:0]   i_mdu_data;

  logic                 o_rf_we;
  logic [RF_ADDR_W-1:0] o_rf_rd;
  logic [P_WIDTH-1:0]   o_rf_wdata;
  logic                 o_busy;

  modport slave (
    input  i_pipe_valid, i_pipe_rd, i_pipe_data, i_mdu_valid, i_mdu_rd, i_mdu_data,
    output o_pipe_stall, o_mdu_ready, o_rf_we, o_rf_rd, o_rf_wdata, o_busy
  );

  modport master (
    output i_pipe_valid, i_pipe_rd, i_pipe_data, i_mdu_valid, i_mdu_rd, i_mdu_data,
    input  o_pipe_stall, o_mdu_ready, o_rf_we, o_rf_rd, o_rf_wdata, o_busy
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO with occupancy count; depth must be a power of 2.
module wb_fifo #(
  parameter int  P_DEPTH = 2,
  parameter type T       = logic [7:0]
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_head,
  output logic [$clog2(P_DEPTH):0] o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(P_DEPTH);

  T                mem_q [P_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok, pop_ok;

  assign o_full  = (count_q == (AW+1)'(P_DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Entry storage.
  // NOTE: the data array has no reset; validity is tracked by count_q alone, so stale contents are harmless.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the writeback
// stage and buffered MDU results, with forced MDU service on a full FIFO or
// a head that waited P_MAX_WAIT cycles.
// Optional: define WB_ARB_PERF_EN to add o_stall_cnt / o_force_cnt counters.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int P_WIDTH    = 32,
  parameter int P_DEPTH    = 2,
  parameter int P_MAX_WAIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wb_port_arbiter_if.slave     bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]          o_stall_cnt,
  output logic [31:0]          o_force_cnt
`endif
);

  localparam int CW = $clog2(P_DEPTH) + 1;
  localparam int WW = $clog2(P_MAX_WAIT + 1);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [P_WIDTH-1:0]   data;
  } req_t;

  wb_arb_state_e        state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CW-1:0]        count, count_after;
  logic                 full, empty, push;
  logic                 grant_pipe, grant_mdu;
  req_t                 mdu_in, head;
  logic                 rf_we_q;
  logic [RF_ADDR_W-1:0] rf_rd_q;
  logic [P_WIDTH-1:0]   rf_wdata_q;

  assign mdu_in           = '{rd: bus.i_mdu_rd, data: bus.i_mdu_data};
  assign bus.o_mdu_ready  = !full && !i_rst;
  assign push             = bus.i_mdu_valid && bus.o_mdu_ready;
  assign bus.o_pipe_stall = (state_q == S_FORCE) && bus.i_pipe_valid;
  assign bus.o_busy       = !empty;
  assign bus.o_rf_we      = rf_we_q;
  assign bus.o_rf_rd      = rf_rd_q;
  assign bus.o_rf_wdata   = rf_wdata_q;

  wb_fifo #(.P_DEPTH(P_DEPTH), .T(req_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (mdu_in),
    .i_pop   (grant_mdu),
    .o_head  (head),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  // Grant selection: forced cycles serve the FIFO, otherwise the pipe wins.
  always_comb begin
    grant_pipe = 1'b0;
    grant_mdu  = 1'b0;
    if (state_q == S_FORCE) grant_mdu = !empty;
    else if (bus.i_pipe_valid) grant_pipe = 1'b1;
    else grant_mdu = !empty;
  end

  // Occupancy after this cycle's push/pop, wait counter and next FSM state.
  always_comb begin
    count_after = count + CW'(push) - CW'(grant_mdu);
    wait_d      = '0;
    if (!empty && !grant_mdu)
      wait_d = (wait_q < WW'(P_MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
    state_d = S_NORMAL;
    if (state_q == S_NORMAL &&
        (count_after == CW'(P_DEPTH) || wait_d >= WW'(P_MAX_WAIT)))
      state_d = S_FORCE;
  end

  // FSM and wait counter state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Registered register-file write; address/data hold when nothing is granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= (grant_pipe && bus.i_pipe_rd != '0) || (grant_mdu && head.rd != '0);
      if (grant_pipe) begin
        rf_rd_q    <= bus.i_pipe_rd;
        rf_wdata_q <= bus.i_pipe_data;
      end else if (grant_mdu) begin
        rf_rd_q    <= head.rd;
        rf_wdata_q <= head.data;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q, force_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_force_cnt = force_cnt_q;

  // Stall-cycle and forced-entry counters, wrapping at 2^32.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (bus.o_pipe_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == S_NORMAL && state_d == S_FORCE) force_cnt_q <= force_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, reset and
// starvation sequences, then random traffic against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.P_WIDTH(32)) bus ();
  wb_port_arbiter_if #(.P_WIDTH(32)) bus4 ();

  wb_port_arbiter #(.P_WIDTH(32), .P_DEPTH(DEPTH), .P_MAX_WAIT(MAXW)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus.slave)
  );
  wb_port_arbiter #(.P_WIDTH(32), .P_DEPTH(4), .P_MAX_WAIT(MAXW)) dut4 (
    .i_clk (clk), .i_rst (rst), .bus (bus4.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.i_pipe_valid = pv; bus.i_pipe_rd = prd; bus.i_pipe_data = pd;
    bus.i_mdu_valid  = mv; bus.i_mdu_rd  = mrd; bus.i_mdu_data  = md;
  endtask

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_stall, e_ready, e_busy, e_we, chk;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mkv(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic st, input logic rdy, input logic bsy, input logic we,
                               input logic chk, input logic [4:0] erd, input logic [31:0] ewd);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_stall = st; v.e_ready = rdy; v.e_busy = bsy; v.e_we = we; v.chk = chk;
    v.e_rd = erd; v.e_wd = ewd;
    return v;
  endfunction

  vec_t vt[17];

  // Reference model: queue of pending MDU results plus wait/force bookkeeping.
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          mw;
  bit          mf;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  logic        r_pv, r_mv, sp, sm, had, e_ready;
  logic [4:0]  r_prd, r_mrd;
  logic [31:0] r_pd, r_md;
  int          stall_k, mdu_k, n_stall, n_pipe_wr;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus4.i_pipe_valid = 0; bus4.i_pipe_rd = 0; bus4.i_pipe_data = 0;
    bus4.i_mdu_valid = 0; bus4.i_mdu_rd = 0; bus4.i_mdu_data = 0;

    //          pv prd pdata         mv mrd mdata       st rdy bsy we chk rd  wdata
    vt[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0,  0,          0, 1, 0, 0, 1, 0,  0);
    vt[1]  = mkv(0, 0, 0,            1, 7,  32'h12,     0, 1, 0, 1, 1, 5,  32'hDEADBEEF);
    vt[2]  = mkv(0, 0, 0,            0, 0,  0,          0, 1, 1, 0, 1, 5,  32'hDEADBEEF);
    vt[3]  = mkv(0, 0, 0,            0, 0,  0,          0, 1, 0, 1, 1, 7,  32'h12);
    vt[4]  = mkv(0, 0, 0,            0, 0,  0,          0, 1, 0, 0, 1, 7,  32'h12);
    vt[5]  = mkv(1, 1, 32'hA1,       1, 10, 32'h100,    0, 1, 0, 0, 1, 7,  32'h12);
    vt[6]  = mkv(1, 2, 32'hA2,       1, 11, 32'h101,    0, 1, 1, 1, 1, 1,  32'hA1);
    vt[7]  = mkv(1, 3, 32'hA3,       1, 12, 32'h102,    1, 0, 1, 1, 1, 2,  32'hA2);
    vt[8]  = mkv(1, 3, 32'hA3,       0, 0,  0,          0, 1, 1, 1, 1, 10, 32'h100);
    vt[9]  = mkv(1, 4, 32'hA4,       0, 0,  0,          0, 1, 1, 1, 1, 3,  32'hA3);
    vt[10] = mkv(1, 5, 32'hA5,       0, 0,  0,          0, 1, 1, 1, 1, 4,  32'hA4);
    vt[11] = mkv(1, 6, 32'hA6,       0, 0,  0,          0, 1, 1, 1, 1, 5,  32'hA5);
    vt[12] = mkv(1, 7, 32'hA7,       0, 0,  0,          1, 1, 1, 1, 1, 6,  32'hA6);
    vt[13] = mkv(1, 7, 32'hA7,       0, 0,  0,          0, 1, 0, 1, 1, 11, 32'h101);
    vt[14] = mkv(1, 0, 32'hBAD0,     1, 0,  32'hBAD1,   0, 1, 0, 1, 1, 7,  32'hA7);
    vt[15] = mkv(0, 0, 0,            0, 0,  0,          0, 1, 1, 0, 0, 0,  0);
    vt[16] = mkv(0, 0, 0,            0, 0,  0,          0, 1, 0, 0, 0, 0,  0);

    repeat (2) @(negedge clk);
    check("rst_mdu_ready", bus.o_mdu_ready, 0);
    check("rst_we", bus.o_rf_we, 0);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i].pv, vt[i].prd, vt[i].pd, vt[i].mv, vt[i].mrd, vt[i].md);
      #1;
      check($sformatf("v%0d_stall", i), bus.o_pipe_stall, vt[i].e_stall);
      check($sformatf("v%0d_ready", i), bus.o_mdu_ready, vt[i].e_ready);
      check($sformatf("v%0d_busy", i), bus.o_busy, vt[i].e_busy);
      check($sformatf("v%0d_we", i), bus.o_rf_we, vt[i].e_we);
      if (vt[i].chk) begin
        check($sformatf("v%0d_rd", i), bus.o_rf_rd, vt[i].e_rd);
        check($sformatf("v%0d_wdata", i), bus.o_rf_wdata, vt[i].e_wd);
      end
    end

    // Reset in the middle of operation with two entries queued.
    @(negedge clk); drive(1, 1, 32'h11, 1, 20, 32'hE0);
    @(negedge clk); drive(1, 2, 32'h22, 1, 21, 32'hE1);
    @(negedge clk); drive(1, 3, 32'h33, 0, 0, 0);
    #1; check("pre_rst_busy", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", bus.o_rf_we, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_ready", bus.o_mdu_ready, 0);
    check("mid_rst_stall", bus.o_pipe_stall, 0);
    check("mid_rst_rd", bus.o_rf_rd, 0);
    check("mid_rst_wdata", bus.o_rf_wdata, 0);
    @(negedge clk);
    check("mid_rst_ready2", bus.o_mdu_ready, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1; check("post_rst_ready", bus.o_mdu_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check($sformatf("post_rst_we%0d", i), bus.o_rf_we, 0);
      check($sformatf("post_rst_busy%0d", i), bus.o_busy, 0);
    end

    // Starvation guard on the depth-4 instance.
    stall_k = -1; mdu_k = -1; n_stall = 0; n_pipe_wr = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus4.i_pipe_valid = 1; bus4.i_pipe_rd = 5'(k + 1); bus4.i_pipe_data = 32'(k);
      bus4.i_mdu_valid = (k == 0); bus4.i_mdu_rd = 9; bus4.i_mdu_data = 32'h55;
      #1;
      if (bus4.o_pipe_stall) begin
        n_stall++;
        if (stall_k < 0) stall_k = k;
      end
      if (bus4.o_rf_we && bus4.o_rf_rd == 9 && bus4.o_rf_wdata == 32'h55 && mdu_k < 0) mdu_k = k;
      else if (bus4.o_rf_we) n_pipe_wr++;
    end
    bus4.i_pipe_valid = 0; bus4.i_mdu_valid = 0;
    check("starve_stall_cycle", 64'(stall_k), 64'(5));
    check("starve_mdu_write_cycle", 64'(mdu_k), 64'(6));
    check("starve_stall_count", 64'(n_stall), 64'(1));
    check("starve_pipe_writes", 64'(n_pipe_wr), 64'(10));

    // Random traffic against the reference model (DUT is idle and empty here).
    mq.delete(); mw = 0; mf = 0; m_we = 0; m_rd = 0; m_wd = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r_pv  = ($urandom % 4) != 0;
      r_prd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      r_pd  = $urandom;
      r_mv  = ($urandom % 3) == 0;
      r_mrd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      r_md  = $urandom;
      drive(r_pv, r_prd, r_pd, r_mv, r_mrd, r_md);
      #1;
      e_ready = mq.size() < DEPTH;
      check("rnd_stall", bus.o_pipe_stall, mf && r_pv);
      check("rnd_ready", bus.o_mdu_ready, e_ready);
      check("rnd_busy", bus.o_busy, mq.size() != 0);
      check("rnd_we", bus.o_rf_we, m_we);
      if (m_we) begin
        check("rnd_rd", bus.o_rf_rd, m_rd);
        check("rnd_wdata", bus.o_rf_wdata, m_wd);
      end
      had = mq.size() != 0;
      sp  = !mf && r_pv;
      sm  = had && (mf || !r_pv);
      m_we = 1'b0;
      if (sp) begin
        m_we = r_prd != 0; m_rd = r_prd; m_wd = r_pd;
      end else if (sm) begin
        m_we = mq[0].rd != 0; m_rd = mq[0].rd; m_wd = mq[0].data;
        void'(mq.pop_front());
      end
      if (r_mv && e_ready) mq.push_back('{rd: r_mrd, data: r_md});
      if (had && !sm) mw = (mw < MAXW) ? mw + 1 : mw;
      else mw = 0;
      mf = !mf && (mq.size() == DEPTH || mw >= MAXW);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
